// File: rtl/instr_mem_axi_rd_slave_if.sv
// AXI4 bus bundle used between the instruction-cache read master and the instruction memory slave.
// Only the read channels carry traffic; the write-channel signals exist so the slave can tie them off.
interface axi_inf #(
    parameter int ADDR_SIZE  = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  ar_valid;
    logic                  ar_ready;
    logic [ADDR_SIZE-1:0]  ar_addr;
    logic [7:0]            ar_len;
    logic [2:0]            ar_size;
    logic [1:0]            ar_burst;

    logic                  r_valid;
    logic                  r_ready;
    logic [DATA_WIDTH-1:0] r_data;
    logic [1:0]            r_resp;
    logic                  r_last;

    logic                  aw_valid;
    logic                  aw_ready;
    logic                  w_valid;
    logic                  w_ready;
    logic                  b_valid;
    logic                  b_ready;
    logic [1:0]            b_resp;

    modport slave (
        input  ar_valid, ar_addr, ar_len, ar_size, ar_burst, r_ready,
        input  aw_valid, w_valid, b_ready,
        output ar_ready, r_valid, r_data, r_resp, r_last,
        output aw_ready, w_ready, b_valid, b_resp
    );

    modport master (
        output ar_valid, ar_addr, ar_len, ar_size, ar_burst, r_ready,
        output aw_valid, w_valid, b_ready,
        input  ar_ready, r_valid, r_data, r_resp, r_last,
        input  aw_ready, w_ready, b_valid, b_resp
    );
endinterface

// File: rtl/instr_mem_axi_rd_slave.sv
// Read-only AXI4 slave serving instruction-fetch bursts from a single-cycle synchronous-read memory.
// INCR and FIXED bursts are served; WRAP, odd sizes and out-of-range beats answer with error responses.
module instr_mem_axi_rd_slave #(
    parameter int                   ADDR_SIZE  = 32,
    parameter int                   DATA_WIDTH = 32,
    parameter int                   MEM_DEPTH  = 1024,
    parameter logic [ADDR_SIZE-1:0] BASE_ADDR  = '0
) (
    input  logic                         i_clk,
    input  logic                         i_areset_n,
    axi_inf.slave                        axi,
    output logic                         o_mem_en,
    output logic [$clog2(MEM_DEPTH)-1:0] o_mem_addr,
    input  logic [DATA_WIDTH-1:0]        i_mem_data,
    output logic [1:0]                   dbg_state
);
    localparam int IDX_W = $clog2(MEM_DEPTH);

    localparam logic [1:0] BURST_INCR = 2'd1;
    localparam logic [1:0] BURST_WRAP = 2'd2;
    localparam logic [1:0] BURST_RSVD = 2'd3;
    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_BURST = 2'd2
    } state_t;

    state_t               state_q;
    logic [ADDR_SIZE-1:0] addr_q;
    logic [7:0]           len_q;
    logic [7:0]           beat_q;
    logic [1:0]           burst_q;
    logic                 err_q;
    logic                 ar_ready_q;
    logic                 r_valid_q;
    logic                 r_last_q;
    logic [1:0]           r_resp_q;

    logic [ADDR_SIZE-1:0] nxt_addr;
    logic [ADDR_SIZE-1:0] cur_off;
    logic [ADDR_SIZE-1:0] nxt_off;
    logic                 cur_ok;
    logic                 nxt_ok;
    logic                 beat_hs;

    // Valid/ready: a beat transfers on a rising edge where r_valid and r_ready are both high;
    // once r_valid rises, r_data/r_resp/r_last stay frozen until that transfer happens.
    assign beat_hs  = r_valid_q && axi.r_ready;

    // Address arithmetic wraps modulo 2^ADDR_SIZE; crossing the top of memory never wraps to word 0.
    assign nxt_addr = (burst_q == BURST_INCR) ? addr_q + ADDR_SIZE'(4) : addr_q;
    assign cur_off  = addr_q - BASE_ADDR;
    assign nxt_off  = nxt_addr - BASE_ADDR;
    assign cur_ok   = (addr_q >= BASE_ADDR) && ((cur_off >> 2) < ADDR_SIZE'(MEM_DEPTH));
    assign nxt_ok   = (nxt_addr >= BASE_ADDR) && ((nxt_off >> 2) < ADDR_SIZE'(MEM_DEPTH));

    function automatic logic [1:0] beat_resp(input logic burst_err, input logic in_range);
        if (burst_err)
            return RESP_SLVERR;
        else if (in_range)
            return RESP_OKAY;
        else
            return RESP_DECERR;
    endfunction

    // The next word is requested in the same cycle the current beat is accepted, giving 1 beat/cycle.
    always_comb begin
        o_mem_en   = 1'b0;
        o_mem_addr = cur_off[IDX_W+1:2];
        if (state_q == S_FETCH) begin
            o_mem_en = !err_q && cur_ok;
        end else if (state_q == S_BURST && beat_hs && !r_last_q) begin
            o_mem_en   = !err_q && nxt_ok;
            o_mem_addr = nxt_off[IDX_W+1:2];
        end
    end

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            beat_q     <= '0;
            burst_q    <= '0;
            err_q      <= 1'b0;
            ar_ready_q <= 1'b1;
            r_valid_q  <= 1'b0;
            r_last_q   <= 1'b0;
            r_resp_q   <= RESP_OKAY;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (axi.ar_valid) begin
                        addr_q     <= axi.ar_addr;
                        len_q      <= axi.ar_len;
                        burst_q    <= axi.ar_burst;
                        beat_q     <= '0;
                        // Reserved burst encoding is refused the same way as WRAP.
                        err_q      <= (axi.ar_burst == BURST_WRAP) || (axi.ar_burst == BURST_RSVD) ||
                                      (axi.ar_size != 3'd2);
                        ar_ready_q <= 1'b0;
                        state_q    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_valid_q <= 1'b1;
                    r_last_q  <= (len_q == 8'd0);
                    r_resp_q  <= beat_resp(err_q, cur_ok);
                    state_q   <= S_BURST;
                end
                S_BURST: begin
                    if (beat_hs) begin
                        if (r_last_q) begin
                            r_valid_q  <= 1'b0;
                            r_last_q   <= 1'b0;
                            r_resp_q   <= RESP_OKAY;
                            ar_ready_q <= 1'b1;
                            state_q    <= S_IDLE;
                        end else begin
                            beat_q   <= beat_q + 8'd1;
                            addr_q   <= nxt_addr;
                            r_last_q <= (8'(beat_q + 8'd1) == len_q);
                            r_resp_q <= beat_resp(err_q, nxt_ok);
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign axi.ar_ready = ar_ready_q;
    assign axi.r_valid  = r_valid_q;
    assign axi.r_last   = r_last_q;
    assign axi.r_resp   = r_resp_q;
    assign axi.r_data   = (r_valid_q && r_resp_q == RESP_OKAY) ? i_mem_data : '0;

    assign axi.aw_ready = 1'b0;
    assign axi.w_ready  = 1'b0;
    assign axi.b_valid  = 1'b0;
    assign axi.b_resp   = RESP_OKAY;

    assign dbg_state = state_q;

    logic unused_inputs;
    assign unused_inputs = ^{axi.aw_valid, axi.w_valid, axi.b_ready};
endmodule

// File: tb/tb_instr_mem_axi_rd_slave.sv
// Directed bench for instr_mem_axi_rd_slave: expected beats go into a queue, a negedge monitor checks them.
module tb_instr_mem_axi_rd_slave;
    localparam logic [1:0] OKAY   = 2'd0;
    localparam logic [1:0] SLVERR = 2'd2;
    localparam logic [1:0] DECERR = 2'd3;
    localparam logic [1:0] FIXED  = 2'd0;
    localparam logic [1:0] INCR   = 2'd1;
    localparam logic [1:0] WRAP   = 2'd2;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_inf #(.ADDR_SIZE(32), .DATA_WIDTH(32)) axi ();

    logic        mem_en;
    logic [9:0]  mem_addr;
    logic [31:0] mem_data;
    logic [1:0]  dbg_state;

    instr_mem_axi_rd_slave #(
        .ADDR_SIZE(32), .DATA_WIDTH(32), .MEM_DEPTH(1024), .BASE_ADDR(32'h0)
    ) dut (
        .i_clk(clk),
        .i_areset_n(rst_n),
        .axi(axi),
        .o_mem_en(mem_en),
        .o_mem_addr(mem_addr),
        .i_mem_data(mem_data),
        .dbg_state(dbg_state)
    );

    // Memory image: word i holds 0xC0DE_0000 | i, output held while enable is low.
    always @(posedge clk) begin
        if (mem_en) mem_data <= 32'hC0DE_0000 | 32'(mem_addr);
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic [34:0] exp_q[$];
    logic        no_en_check = 1'b0;
    logic        prev_stall  = 1'b0;
    logic [34:0] held        = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [34:0] beat(input logic [1:0] resp, input logic last, input logic [31:0] data);
        return {resp, last, data};
    endfunction

    // scoreboard monitor
    always @(negedge clk) begin
        logic [34:0] cur;
        logic [34:0] e;
        cur = {axi.r_resp, axi.r_last, axi.r_data};
        if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid_held", 64'(axi.r_valid), 64'd1);
                if (axi.r_valid) check("stall_stable", 64'(cur), 64'(held));
            end
            if (axi.r_valid && axi.r_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_beat actual=%0h required=none (t=%0t)", cur, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("r_beat", 64'(cur), 64'(e));
                end
            end
            if (axi.r_valid && !axi.r_ready) check("stall_mem_en", 64'(mem_en), 64'd0);
            if (no_en_check) check("err_mem_en", 64'(mem_en), 64'd0);
            prev_stall <= axi.r_valid && !axi.r_ready;
            held       <= cur;
        end
    end

    // driver tasks
    task automatic send_ar(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic [2:0] size, output int hs);
        axi.ar_addr  = addr;
        axi.ar_len   = len;
        axi.ar_burst = burst;
        axi.ar_size  = size;
        axi.ar_valid = 1'b1;
        hs = -1;
        for (int n = 0; n < 50; n++) begin
            if (axi.ar_ready) begin
                @(posedge clk); #1;
                hs = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        axi.ar_valid = 1'b0;
        if (hs < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL ar_timeout actual=no_arready required=arready addr=%0h", addr);
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 300; n++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk); #1;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int h1, h2;
        int pat[7];
        pat = '{1, 0, 0, 1, 1, 0, 1};
        axi.ar_valid = 1'b0;
        axi.ar_addr  = '0;
        axi.ar_len   = '0;
        axi.ar_size  = 3'd2;
        axi.ar_burst = INCR;
        axi.r_ready  = 1'b1;
        axi.aw_valid = 1'b0;
        axi.w_valid  = 1'b0;
        axi.b_ready  = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_r_valid", 64'(axi.r_valid), 64'd0);
        check("rst_mem_en", 64'(mem_en), 64'd0);
        check("rst_ar_ready", 64'(axi.ar_ready), 64'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_state", 64'(dbg_state), 64'd0);
        check("idle_r_last", 64'(axi.r_last), 64'd0);
        check("idle_r_resp", 64'(axi.r_resp), 64'(OKAY));
        check("tie_aw_ready", 64'(axi.aw_ready), 64'd0);
        check("tie_w_ready", 64'(axi.w_ready), 64'd0);
        check("tie_b_valid", 64'(axi.b_valid), 64'd0);

        // single beat with cycle-exact timing
        exp_q.push_back(beat(OKAY, 1'b1, 32'hC0DE_0004));
        send_ar(32'h0000_0010, 8'd0, INCR, 3'd2, h1);
        check("single_mem_en_t1", 64'(mem_en), 64'd1);
        check("single_mem_addr_t1", 64'(mem_addr), 64'd4);
        @(posedge clk); #1;
        check("single_r_valid_t2", 64'(axi.r_valid), 64'd1);
        check("single_r_last_t2", 64'(axi.r_last), 64'd1);
        @(posedge clk); #1;
        check("single_idle_t3", 64'(axi.ar_ready), 64'd1);
        check("single_r_valid_t3", 64'(axi.r_valid), 64'd0);
        drain();

        // 4-beat INCR followed by back-to-back FIXED burst
        for (int i = 0; i < 4; i++)
            exp_q.push_back(beat(OKAY, i == 3, 32'hC0DE_0010 + 32'(i)));
        for (int i = 0; i < 3; i++)
            exp_q.push_back(beat(OKAY, i == 2, 32'hC0DE_0020));
        send_ar(32'h0000_0040, 8'd3, INCR, 3'd2, h1);
        send_ar(32'h0000_0080, 8'd2, FIXED, 3'd2, h2);
        check("b2b_ar_cycle", 64'(h2 - h1), 64'd6);
        drain();

        // backpressure on the same 4-beat burst
        for (int i = 0; i < 4; i++)
            exp_q.push_back(beat(OKAY, i == 3, 32'hC0DE_0010 + 32'(i)));
        send_ar(32'h0000_0040, 8'd3, INCR, 3'd2, h1);
        @(posedge clk); #1;
        for (int k = 0; k < 7; k++) begin
            axi.r_ready = (pat[k] != 0);
            @(posedge clk); #1;
        end
        axi.r_ready = 1'b1;
        drain();

        // WRAP and bad size: SLVERR beats, memory never enabled
        no_en_check = 1'b1;
        for (int i = 0; i < 4; i++)
            exp_q.push_back(beat(SLVERR, i == 3, 32'h0));
        send_ar(32'h0000_0040, 8'd3, WRAP, 3'd2, h1);
        drain();
        for (int i = 0; i < 2; i++)
            exp_q.push_back(beat(SLVERR, i == 1, 32'h0));
        send_ar(32'h0000_0010, 8'd1, INCR, 3'd1, h1);
        drain();
        no_en_check = 1'b0;

        // crossing the top of memory
        exp_q.push_back(beat(OKAY, 1'b0, 32'hC0DE_03FE));
        exp_q.push_back(beat(OKAY, 1'b0, 32'hC0DE_03FF));
        exp_q.push_back(beat(DECERR, 1'b0, 32'h0));
        exp_q.push_back(beat(DECERR, 1'b1, 32'h0));
        send_ar(32'h0000_0FF8, 8'd3, INCR, 3'd2, h1);
        drain();

        // unaligned address returns the containing word
        exp_q.push_back(beat(OKAY, 1'b1, 32'hC0DE_0004));
        send_ar(32'h0000_0013, 8'd0, INCR, 3'd2, h1);
        drain();

        // reset while beat 2 of an 8-beat burst is presented
        exp_q.push_back(beat(OKAY, 1'b0, 32'hC0DE_0040));
        exp_q.push_back(beat(OKAY, 1'b0, 32'hC0DE_0041));
        send_ar(32'h0000_0100, 8'd7, INCR, 3'd2, h1);
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("pre_reset_r_valid", 64'(axi.r_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("reset_r_valid_async", 64'(axi.r_valid), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("post_reset_r_valid", 64'(axi.r_valid), 64'd0);
        end
        check("post_reset_state", 64'(dbg_state), 64'd0);
        check("post_reset_ar_ready", 64'(axi.ar_ready), 64'd1);
        check("post_reset_queue", 64'(exp_q.size()), 64'd0);
        exp_q.push_back(beat(OKAY, 1'b1, 32'hC0DE_0004));
        send_ar(32'h0000_0010, 8'd0, INCR, 3'd2, h1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_mem_axi_rd_slave.md
Name: instr_mem_axi_rd_slave

Overview:
- AXI4 read-only slave that serves instruction-fetch bursts from the instruction cache controller (the AXI read master).
- Backed by an external synchronous-read memory with single-cycle latency, e.g. a BRAM holding program image.
- Supports INCR and FIXED bursts, 32-bit beats, up to 256 beats.
- Returns error responses for unsupported bursts and out-of-range addresses.

Parameters:
- ADDR_SIZE, 32, AXI address width in bits.
- DATA_WIDTH, 32, beat width; must equal INST_SIZE.
- MEM_DEPTH, 1024, number of 32-bit words in backing memory.
- BASE_ADDR, 0, byte address mapped to memory word 0.

Ports:
- i_clk  input  1  system clock; all logic rising-edge.
- i_areset_n  input  1  asynchronous, active-low reset.
- axi  interface  axi_inf.slave  AXI4 bus; AR/R channels active, AW/W/B tied off.
- o_mem_en  output  1  memory read enable.
- o_mem_addr  output  $clog2(MEM_DEPTH)  memory word index.
- i_mem_data  input  DATA_WIDTH  memory read data; valid one cycle after o_mem_en; memory holds it while o_mem_en is low.

Behaviour:
- Reset (async assert, sync-safe release):
  - state=IDLE; axi.r.valid=0, r.last=0, r.resp=OKAY.
  - o_mem_en=0; beat counter=0; captured address/len/burst cleared.
  - Reset mid-burst abandons the burst immediately; no further beats after release.
- Write tie-off, constant: awready=0, wready=0, b.valid=0.
- State machine:
  - IDLE: arready=1.
    - On ar.valid: capture addr, len, size, burst; beat=0; compute err; -> FETCH.
  - FETCH: arready=0; o_mem_en=~err; o_mem_addr=word index of captured addr; -> BURST.
  - BURST: r.valid=1; r.last=(beat==len).
    - On r.valid&rready with last: -> IDLE.
    - On r.valid&rready, not last:
      - beat+=1.
      - INCR: addr+=4. FIXED: addr unchanged.
      - Same cycle: o_mem_en=~err, o_mem_addr=next word index; stay BURST.
    - On rready=0: hold all r signals stable; o_mem_en=0; memory output holds.
- r.data: i_mem_data when beat is OKAY, else 0.
- Error rules:
  - err (burst-level) set when burst==WRAP or size!=2. Every beat returns SLVERR; no memory reads; still exactly len+1 beats with correct last.
  - Per-beat: word index = (addr-BASE_ADDR)>>2. If addr<BASE_ADDR or index>=MEM_DEPTH, that beat returns DECERR, data 0, o_mem_en=0.
  - An INCR burst crossing the top of memory returns OKAY beats then DECERR beats; no wrap-around to word 0.
  - addr arithmetic is ADDR_SIZE bits, modulo 2^ADDR_SIZE.
- Timing:
  - AR handshake at cycle T; first r.valid at T+2.
  - With rready held high, 1 beat/cycle.
  - After the last beat is accepted, IDLE for one cycle, then the next AR is accepted; minimum 1 bubble between bursts.
- Unaligned addr (addr[1:0]!=0): index uses addr>>2; data returned for the aligned word, resp OKAY.
- r.valid never drops before handshake; r.data, r.resp and r.last are stable while r.valid&~rready.

Test Plan:
- Single beat: AR addr=0x0000_0010, len=0, INCR, size=2 -> o_mem_addr=4 at T+1; r.valid, r.last=1, data=mem[4], OKAY at T+2; IDLE at T+3.
- 4-beat INCR, rready=1: addr=0x40, len=3 -> mem[16..19] on consecutive cycles T+2..T+5; r.last only on the 4th beat; second back-to-back AR accepted at T+6.
- Backpressure: same 4-beat burst with rready pattern 1,0,0,1,1,0,1 -> data/resp/last stable during stalls; no repeated or skipped words; o_mem_en=0 during stalls.
- FIXED and WRAP: FIXED addr=0x80, len=2 -> mem[32] three times, last on 3rd. WRAP len=3 -> four SLVERR beats, data 0, o_mem_en never asserted.
- Range boundary (MEM_DEPTH=1024): INCR addr=0xFF8, len=3 -> mem[1022], mem[1023] OKAY, then 2 DECERR beats with data 0.
- Reset mid-burst: assert i_areset_n=0 during beat 2 of an 8-beat burst -> r.valid=0 immediately; after release, IDLE with arready=1 and new AR served normally.
